// File: rtl/cp0_timer_ctrl.sv
// MEM-stage coprocessor 0: SR/Cause/EPC/PrID, Count/Compare timer, interrupt/exception
// arbitration and kernel-entry/ERET control for the pipeline controller.
module cp0_timer_ctrl #(
   parameter int unsigned NUM_HWINT = 6,
   parameter int unsigned COUNT_DIV = 1,
   parameter logic [31:0] RESET_EPC = 32'h0000_3000,
   parameter logic [31:0] PRID      = 32'hBAAD_FACE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_i,
   input  logic                 stall_i,
   input  logic                 is_mfc0_i,
   input  logic                 is_mtc0_i,
   input  logic                 is_eret_i,
   input  logic [4:0]           cp0_id_i,
   input  logic [31:0]          wdata_i,
   input  logic [31:0]          pc_i,
   input  logic                 bd_i,
   input  logic [4:0]           exc_in_i,
   input  logic [NUM_HWINT-1:0] hw_int_i,
   output logic [1:0]           kctrl_o,
   output logic [31:0]          epc_out_o,
   output logic [31:0]          rdata_o,
   output logic                 is_bd_o,
   output logic                 timer_int_o
);

   localparam int unsigned PrescW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PrescW-1:0] PrescMax = PrescW'(COUNT_DIV - 1);
   // IM bits for absent lines stay 0; IM[15] always exists for the timer.
   localparam logic [5:0] ImMask = 6'((32'd1 << NUM_HWINT) - 32'd1) | 6'b10_0000;

   localparam logic [4:0] RegCount   = 5'd9;
   localparam logic [4:0] RegCompare = 5'd11;
   localparam logic [4:0] RegSr      = 5'd12;
   localparam logic [4:0] RegCause   = 5'd13;
   localparam logic [4:0] RegEpc     = 5'd14;
   localparam logic [4:0] RegPrid    = 5'd15;

   logic [5:0]        im_q, im_d;
   logic              exl_q, exl_d;
   logic              ie_q, ie_d;
   logic [5:0]        hw_q, hw_d;
   logic [4:0]        code_q, code_d;
   logic              bd_q, bd_d;
   logic              ti_q, ti_d;
   logic [31:2]       epc_q, epc_d;
   logic [31:0]       count_q, count_d;
   logic [31:0]       compare_q, compare_d;
   logic [PrescW-1:0] presc_q, presc_d;

   logic [5:0]  ip;
   logic [5:0]  hw_ext;
   logic        int_req, exc_req, act, take, mtc0_wr;
   logic [31:0] count_inc, sr_word, cause_word;
   logic        unused_pc;

   assign unused_pc = ^pc_i[1:0];

   always_comb begin
      hw_ext = '0;
      hw_ext[NUM_HWINT-1:0] = hw_int_i;
   end

   assign ip         = {ti_q | hw_q[5], hw_q[4:0]};
   assign int_req    = (|(ip & im_q)) & ie_q & ~exl_q;
   assign exc_req    = |exc_in_i;
   assign act        = valid_i & ~stall_i;
   assign take       = act & (int_req | exc_req);
   assign mtc0_wr    = act & ~take & is_mtc0_i;
   assign count_inc  = count_q + 32'd1;
   assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
   assign cause_word = {bd_q, ti_q, 14'b0, ip, 3'b0, code_q, 2'b0};

   always_comb begin
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      hw_d      = hw_ext;
      code_d    = code_q;
      bd_d      = bd_q;
      ti_d      = ti_q;
      epc_d     = epc_q;
      count_d   = count_q;
      compare_d = compare_q;
      presc_d   = (presc_q == PrescMax) ? '0 : presc_q + PrescW'(1);

      if (take) begin
         exl_d  = 1'b1;
         code_d = int_req ? 5'd0 : exc_in_i;
         bd_d   = bd_i;
         // Delay-slot traps restart at the branch, one word earlier.
         epc_d  = pc_i[31:2] - {29'b0, bd_i};
      end else if (act && is_eret_i) begin
         exl_d  = 1'b0;
         code_d = 5'd0;
         bd_d   = 1'b0;
      end

      if (mtc0_wr) begin
         case (cp0_id_i)
            RegSr: begin
               im_d  = wdata_i[15:10] & ImMask;
               exl_d = wdata_i[1];
               ie_d  = wdata_i[0];
            end
            RegEpc:  epc_d = wdata_i[31:2];
            default: ;
         endcase
      end

      if (mtc0_wr && cp0_id_i == RegCount) begin
         count_d = wdata_i;
         presc_d = '0;
      end else if (presc_q == PrescMax) begin
         count_d = count_inc;
         if (count_inc == compare_q) ti_d = 1'b1;
      end

      // A Compare write acknowledges the timer and beats a same-cycle match.
      if (mtc0_wr && cp0_id_i == RegCompare) begin
         compare_d = wdata_i;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         im_q      <= ImMask;
         exl_q     <= 1'b0;
         ie_q      <= 1'b1;
         hw_q      <= '0;
         code_q    <= '0;
         bd_q      <= 1'b0;
         ti_q      <= 1'b0;
         epc_q     <= RESET_EPC[31:2];
         count_q   <= '0;
         compare_q <= 32'hFFFF_FFFF;
         presc_q   <= '0;
      end else begin
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         hw_q      <= hw_d;
         code_q    <= code_d;
         bd_q      <= bd_d;
         ti_q      <= ti_d;
         epc_q     <= epc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         presc_q   <= presc_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      if (is_mfc0_i) begin
         case (cp0_id_i)
            RegCount:   rdata_o = count_q;
            RegCompare: rdata_o = compare_q;
            RegSr:      rdata_o = sr_word;
            RegCause:   rdata_o = cause_word;
            RegEpc:     rdata_o = {epc_q, 2'b00};
            RegPrid:    rdata_o = PRID;
            default:    rdata_o = '0;
         endcase
      end
   end

   assign kctrl_o     = take ? 2'b01 : (act && is_eret_i) ? 2'b10 : 2'b00;
   assign is_bd_o     = take & bd_i;
   assign epc_out_o   = {epc_q, 2'b00};
   assign timer_int_o = ti_q;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Bench for cp0_timer_ctrl: directed vector table, timer sequences, randomized traffic
// against an architectural model, and an asynchronous reset in mid-run.
module tb_cp0_timer_ctrl;
   localparam int unsigned NumHw = 6;
   localparam int unsigned Div   = 2;

   typedef struct packed {
      logic        valid;
      logic        stall;
      logic        mfc0;
      logic        mtc0;
      logic        eret;
      logic [4:0]  id;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
   } stim_t;

   typedef struct packed {
      stim_t       s;
      logic [1:0]  kctrl;
      logic [31:0] rdata;
      logic        is_bd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, stall, is_mfc0, is_mtc0, is_eret, bd;
   logic [4:0]  cp0_id, exc_in;
   logic [31:0] wdata, pc;
   logic [5:0]  hw_int;
   logic [1:0]  kctrl;
   logic [31:0] epc_out, rdata;
   logic        is_bd, timer_int;

   int n_pass  = 0;
   int n_total = 0;
   vec_t tbl[$];

   // Architectural model state: whole SR word, Cause fields, timer as base + elapsed ticks.
   logic [31:0] m_sr, m_epc, m_base, m_compare;
   int unsigned m_ticks;
   logic        m_ti, m_bd;
   logic [4:0]  m_code;
   logic [5:0]  m_hw;

   cp0_timer_ctrl #(
      .NUM_HWINT(NumHw),
      .COUNT_DIV(Div),
      .RESET_EPC(32'h0000_3000),
      .PRID     (32'hBAAD_FACE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (valid),
      .stall_i    (stall),
      .is_mfc0_i  (is_mfc0),
      .is_mtc0_i  (is_mtc0),
      .is_eret_i  (is_eret),
      .cp0_id_i   (cp0_id),
      .wdata_i    (wdata),
      .pc_i       (pc),
      .bd_i       (bd),
      .exc_in_i   (exc_in),
      .hw_int_i   (hw_int),
      .kctrl_o    (kctrl),
      .epc_out_o  (epc_out),
      .rdata_o    (rdata),
      .is_bd_o    (is_bd),
      .timer_int_o(timer_int)
   );

   always #5 clk = ~clk;

   function automatic stim_t st(logic v, logic sl, logic r, logic w, logic e, logic [4:0] id,
                                logic [31:0] wd, logic [31:0] p, logic b, logic [4:0] x,
                                logic [5:0] h);
      stim_t s;
      s.valid = v; s.stall = sl; s.mfc0 = r; s.mtc0 = w; s.eret = e; s.id = id;
      s.wdata = wd; s.pc = p; s.bd = b; s.exc = x; s.hw = h;
      return s;
   endfunction

   function automatic stim_t rd(logic [4:0] id);
      return st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, id, 32'h0, 32'h3000, 1'b0, 5'd0, 6'h00);
   endfunction

   function automatic stim_t wr(logic [4:0] id, logic [31:0] d);
      return st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, id, d, 32'h3000, 1'b0, 5'd0, 6'h00);
   endfunction

   function automatic stim_t eret_op();
      return st(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h3000, 1'b0, 5'd0, 6'h00);
   endfunction

   task automatic add(stim_t s, logic [1:0] k, logic [31:0] r, logic b);
      vec_t v;
      v.s = s; v.kctrl = k; v.rdata = r; v.is_bd = b;
      tbl.push_back(v);
   endtask

   function automatic logic [31:0] m_count();
      return m_base + 32'(m_ticks / Div);
   endfunction

   function automatic logic [5:0] m_ip();
      return {m_ti | m_hw[5], m_hw[4:0]};
   endfunction

   function automatic logic m_int();
      return ((m_ip() & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic [31:0] m_read(logic [4:0] id);
      case (id)
         5'd9:    return m_count();
         5'd11:   return m_compare;
         5'd12:   return m_sr;
         5'd13:   return {m_bd, m_ti, 14'b0, m_ip(), 3'b0, m_code, 2'b0};
         5'd14:   return m_epc;
         5'd15:   return 32'hBAAD_FACE;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_sr = 32'h0000_FC01; m_epc = 32'h0000_3000; m_base = 32'h0; m_ticks = 0;
      m_compare = 32'hFFFF_FFFF; m_ti = 1'b0; m_bd = 1'b0; m_code = 5'd0; m_hw = 6'h00;
   endtask

   task automatic model_out(stim_t s, output logic [1:0] k, output logic [31:0] r,
                            output logic b);
      logic act, take;
      act  = s.valid && !s.stall;
      take = act && (m_int() || s.exc != 5'd0);
      k = take ? 2'b01 : (act && s.eret) ? 2'b10 : 2'b00;
      r = s.mfc0 ? m_read(s.id) : 32'h0;
      b = take && s.bd;
   endtask

   task automatic model_step(stim_t s);
      logic act, intr, take, cnt_wr, cmp_wr;
      logic [31:0] old_count;
      act    = s.valid && !s.stall;
      intr   = m_int();
      take   = act && (intr || s.exc != 5'd0);
      cnt_wr = 1'b0;
      cmp_wr = 1'b0;
      old_count = m_count();
      if (take) begin
         m_sr[1] = 1'b1;
         m_code  = intr ? 5'd0 : s.exc;
         m_bd    = s.bd;
         m_epc   = (s.bd ? s.pc - 32'd4 : s.pc) & ~32'h3;
      end else if (act) begin
         if (s.eret) begin
            m_sr[1] = 1'b0; m_code = 5'd0; m_bd = 1'b0;
         end
         if (s.mtc0) begin
            case (s.id)
               5'd12:   m_sr = s.wdata & 32'h0000_FC03;
               5'd14:   m_epc = s.wdata & ~32'h3;
               5'd9:    cnt_wr = 1'b1;
               5'd11:   cmp_wr = 1'b1;
               default: ;
            endcase
         end
      end
      m_ticks++;
      if (cnt_wr) begin
         m_base = s.wdata; m_ticks = 0;
      end else if (m_count() != old_count && m_count() == m_compare) begin
         m_ti = 1'b1;
      end
      if (cmp_wr) begin
         m_compare = s.wdata; m_ti = 1'b0;
      end
      m_hw = s.hw;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic apply(stim_t s);
      valid = s.valid; stall = s.stall; is_mfc0 = s.mfc0; is_mtc0 = s.mtc0;
      is_eret = s.eret; cp0_id = s.id; wdata = s.wdata; pc = s.pc; bd = s.bd;
      exc_in = s.exc; hw_int = s.hw;
   endtask

   task automatic drive(stim_t s);
      @(negedge clk);
      apply(s);
      #1;
   endtask

   task automatic clock(stim_t s);
      @(posedge clk);
      model_step(s);
   endtask

   task automatic cmp_model(stim_t s, string tag);
      logic [1:0] k;
      logic [31:0] r;
      logic b;
      model_out(s, k, r, b);
      check({tag, " kctrl"}, 32'(kctrl), 32'(k));
      check({tag, " rdata"}, rdata, r);
      check({tag, " is_bd"}, 32'(is_bd), 32'(b));
      check({tag, " epc_out"}, epc_out, m_epc);
      check({tag, " timer_int"}, 32'(timer_int), 32'(m_ti));
   endtask

   task automatic cycle(stim_t s, string tag);
      drive(s);
      cmp_model(s, tag);
      clock(s);
   endtask

   initial begin
      stim_t s;
      logic [5:0] hw_cur;
      int unsigned op;
      logic [4:0] ids [8];

      ids = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd7};

      add(rd(5'd12), 2'b00, 32'h0000_FC01, 1'b0);
      add(rd(5'd15), 2'b00, 32'hBAAD_FACE, 1'b0);
      add(rd(5'd14), 2'b00, 32'h0000_3000, 1'b0);
      add(rd(5'd11), 2'b00, 32'hFFFF_FFFF, 1'b0);
      add(rd(5'd13), 2'b00, 32'h0, 1'b0);
      add(rd(5'd3),  2'b00, 32'h0, 1'b0);
      add(st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 5'd0, 6'h04),
          2'b00, 32'h0, 1'b0);
      add(st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 32'h3010, 1'b0, 5'd0, 6'h04),
          2'b01, 32'h0000_1000, 1'b0);
      add(rd(5'd14), 2'b00, 32'h0000_3010, 1'b0);
      add(rd(5'd12), 2'b00, 32'h0000_FC03, 1'b0);
      add(rd(5'd13), 2'b00, 32'h0, 1'b0);
      add(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h3024, 1'b1, 5'd4, 6'h00),
          2'b01, 32'h0, 1'b1);
      add(rd(5'd14), 2'b00, 32'h0000_3020, 1'b0);
      add(rd(5'd13), 2'b00, 32'h8000_0010, 1'b0);
      add(eret_op(), 2'b10, 32'h0, 1'b0);
      add(rd(5'd13), 2'b00, 32'h0, 1'b0);
      add(rd(5'd12), 2'b00, 32'h0000_FC01, 1'b0);
      add(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'h01),
          2'b00, 32'h0, 1'b0);
      add(st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0, 32'h3030, 1'b0, 5'd5, 6'h01),
          2'b01, 32'h0, 1'b0);
      add(rd(5'd13), 2'b00, 32'h0000_0400, 1'b0);
      add(rd(5'd12), 2'b00, 32'h0000_FC03, 1'b0);
      add(eret_op(), 2'b10, 32'h0, 1'b0);
      add(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'h02),
          2'b00, 32'h0, 1'b0);
      add(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h3040, 1'b0, 5'd0, 6'h02),
          2'b00, 32'h0, 1'b0);
      add(st(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd14, 32'h0, 32'h3040, 1'b0, 5'd0, 6'h02),
          2'b00, 32'h0000_3030, 1'b0);
      add(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h3040, 1'b0, 5'd0, 6'h02),
          2'b01, 32'h0, 1'b0);
      add(rd(5'd14), 2'b00, 32'h0000_3040, 1'b0);
      add(eret_op(), 2'b10, 32'h0, 1'b0);
      add(wr(5'd12, 32'h0), 2'b00, 32'h0, 1'b0);
      add(rd(5'd12), 2'b00, 32'h0, 1'b0);
      add(wr(5'd14, 32'h0000_1237), 2'b00, 32'h0, 1'b0);
      add(rd(5'd14), 2'b00, 32'h0000_1234, 1'b0);
      add(wr(5'd13, 32'hFFFF_FFFF), 2'b00, 32'h0, 1'b0);
      add(rd(5'd13), 2'b00, 32'h0, 1'b0);
      add(wr(5'd12, 32'h0000_FC01), 2'b00, 32'h0, 1'b0);
      add(rd(5'd12), 2'b00, 32'h0000_FC01, 1'b0);
      add(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0, 32'h3000, 1'b0, 5'd0, 6'h00),
          2'b00, 32'h0, 1'b0);

      // Reset
      rst_n = 1'b0;
      apply(st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00));
      m_reset();
      #12;
      check("reset kctrl", 32'(kctrl), 32'h0);
      check("reset epc_out", epc_out, 32'h0000_3000);
      check("reset timer_int", 32'(timer_int), 32'h0);
      check("reset is_bd", 32'(is_bd), 32'h0);
      check("reset sr", rdata, 32'h0000_FC01);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].s);
         check($sformatf("vec%0d kctrl", i), 32'(kctrl), 32'(tbl[i].kctrl));
         check($sformatf("vec%0d rdata", i), rdata, tbl[i].rdata);
         check($sformatf("vec%0d is_bd", i), 32'(is_bd), 32'(tbl[i].is_bd));
         check($sformatf("vec%0d epc_out", i), epc_out, m_epc);
         clock(tbl[i].s);
      end

      // Compare=5 with Count restarted: TI appears 10 cycles later (COUNT_DIV=2).
      cycle(wr(5'd12, 32'h0000_FC00), "ie off");
      cycle(wr(5'd11, 32'd5), "cmp5");
      cycle(wr(5'd9, 32'd0), "cnt0");
      for (int k = 1; k <= 11; k++) begin
         drive(rd(5'd9));
         check($sformatf("tmr%0d count", k), rdata, 32'((k - 1) / 2));
         check($sformatf("tmr%0d ti", k), 32'(timer_int), (k == 11) ? 32'd1 : 32'd0);
         clock(rd(5'd9));
      end
      drive(rd(5'd13));
      check("ti cause", rdata, 32'h4000_8000);
      clock(rd(5'd13));
      cycle(wr(5'd11, 32'h100), "cmp clr");
      drive(rd(5'd11));
      check("ti cleared", 32'(timer_int), 32'h0);
      check("cmp readback", rdata, 32'h100);
      clock(rd(5'd11));

      // Count wrap FFFF_FFFF -> 0 matching Compare=0.
      cycle(wr(5'd11, 32'h0), "cmp0");
      cycle(wr(5'd9, 32'hFFFF_FFFF), "cntmax");
      for (int k = 1; k <= 3; k++) begin
         drive(rd(5'd9));
         check($sformatf("wrap%0d count", k), rdata, (k == 3) ? 32'h0 : 32'hFFFF_FFFF);
         check($sformatf("wrap%0d ti", k), 32'(timer_int), (k == 3) ? 32'd1 : 32'd0);
         clock(rd(5'd9));
      end
      cycle(wr(5'd11, 32'hFFFF_0000), "cmp far");
      cycle(wr(5'd12, 32'h0000_FC01), "sr restore");

      hw_cur = 6'h00;
      for (int i = 0; i < 600; i++) begin
         s = '0;
         s.valid = ($urandom_range(0, 3) != 0);
         s.stall = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 9) == 0) s.exc = 5'($urandom_range(1, 31));
         s.bd = 1'($urandom_range(0, 1));
         s.pc = $urandom;
         if ($urandom_range(0, 7) == 0) hw_cur = 6'($urandom);
         s.hw = hw_cur;
         s.id = ids[$urandom_range(0, 7)];
         op = $urandom_range(0, 9);
         if (op <= 2) s.mfc0 = 1'b1;
         else if (op <= 5) s.mtc0 = 1'b1;
         else if (op == 6) s.eret = 1'b1;
         s.wdata = (s.id == 5'd9 || s.id == 5'd11) ? 32'($urandom_range(0, 12)) : $urandom;
         cycle(s, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of a low clock phase.
      drive(st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00));
      #2;
      rst_n = 1'b0;
      #1;
      check("async epc_out", epc_out, 32'h0000_3000);
      check("async timer_int", 32'(timer_int), 32'h0);
      check("async sr", rdata, 32'h0000_FC01);
      check("async kctrl", 32'(kctrl), 32'h0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(rd(5'd11), "post cmp");
      cycle(rd(5'd13), "post cause");
      cycle(rd(5'd9), "post count");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
